// File: rtl/ex_is_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : ex_is_stage_ctrl_if
// Brief   : Handshake and register-control bundle between the EX/IS stage
//           controller, its upstream producer and the EX/IS pipeline register.
// Rev     : 1.0 - initial release
// ============================================================================
interface ex_is_stage_ctrl_if #(
    parameter int NrOfBits = 32
);
    logic                tick;
    logic                in_valid;
    logic [NrOfBits-1:0] in_imm;
    logic                in_multicycle;
    logic                in_kill;
    logic                in_ready;
    logic                out_ready;
    logic                out_valid;
    logic [NrOfBits-1:0] imm_d;
    logic                clock_enable;
    logic                flush;
    logic [15:0]         stall_cnt;

    // Controller side
    modport slave (
        input  tick,
        input  in_valid,
        input  in_imm,
        input  in_multicycle,
        input  in_kill,
        input  out_ready,
        output in_ready,
        output out_valid,
        output imm_d,
        output clock_enable,
        output flush,
        output stall_cnt
    );

    // Environment side (upstream producer + pipeline register)
    modport master (
        output tick,
        output in_valid,
        output in_imm,
        output in_multicycle,
        output in_kill,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  imm_d,
        input  clock_enable,
        input  flush,
        input  stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ex_is_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ex_is_stage_ctrl
// Brief   : EX/IS stage controller - latches an immediate, stalls for
//           multicycle ops, applies backpressure and drives the EX/IS register
//           ClockEnable / Flush.
// Rev     : 1.0 - initial release
// ============================================================================
module ex_is_stage_ctrl #(
    parameter int NrOfBits   = 32,
    parameter int MulLatency = 3    // legal range 1..15
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    ex_is_stage_ctrl_if.slave  bus
);

    localparam logic [3:0]  C_CNT_INIT = 4'(MulLatency - 1);
    localparam logic [15:0] C_STALL_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [NrOfBits-1:0] r_imm;
    logic                r_out_valid;
    logic                r_flush;
    logic [15:0]         r_stall_cnt;

    logic w_kill;
    logic w_in_ready;
    logic w_accept;
    logic w_stall;

    assign w_kill = bus.in_kill & bus.tick;

    // rst_n gates in_ready so upstream never sees a ready while held in reset
    assign w_in_ready = rst_n & ((r_state == S_IDLE) |
                                 ((r_state == S_HOLD) & bus.out_ready));

    assign w_accept = bus.in_valid & w_in_ready & bus.tick & ~w_kill;

    assign w_stall = bus.tick & ((r_state == S_WAIT) |
                                 ((r_state == S_HOLD) & ~bus.out_ready));

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.imm_d        = r_imm;
    assign bus.clock_enable = r_out_valid & bus.out_ready & bus.tick & ~w_kill;
    assign bus.flush        = r_flush;
    assign bus.stall_cnt    = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_imm       <= '0;
            r_out_valid <= 1'b0;
            r_flush     <= 1'b0;
            r_stall_cnt <= 16'd0;
        end else begin
            if (w_stall && (r_stall_cnt != C_STALL_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end

            if (w_kill) begin
                r_state     <= S_FLUSH;
                r_cnt       <= 4'd0;
                r_imm       <= '0;
                r_out_valid <= 1'b0;
                r_flush     <= 1'b1;
            end else if (w_accept) begin
                // Covers both a fresh accept in IDLE and a back-to-back one in HOLD
                r_imm   <= bus.in_imm;
                r_flush <= 1'b0;
                if (bus.in_multicycle) begin
                    r_state     <= S_WAIT;
                    r_cnt       <= C_CNT_INIT;
                    r_out_valid <= 1'b0;
                end else begin
                    r_state     <= S_HOLD;
                    r_cnt       <= 4'd0;
                    r_out_valid <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_out_valid <= 1'b0;
                        r_flush     <= 1'b0;
                    end
                    S_WAIT: begin
                        if (bus.tick) begin
                            if (r_cnt == 4'd0) begin
                                r_state     <= S_HOLD;
                                r_out_valid <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt - 4'd1;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (bus.tick && bus.out_ready) begin
                            r_state     <= S_IDLE;
                            r_out_valid <= 1'b0;
                        end
                    end
                    S_FLUSH: begin
                        // Flush is a single-cycle register reset pulse, so leave
                        // FLUSH on the next edge even without a Tick
                        r_state <= S_IDLE;
                        r_flush <= 1'b0;
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_flush     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_is_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex_is_stage_ctrl
// Brief   : Directed, table-driven self-checking bench for ex_is_stage_ctrl.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_ex_is_stage_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    ex_is_stage_ctrl_if #(.NrOfBits(32)) bus ();

    ex_is_stage_ctrl #(
        .NrOfBits   (32),
        .MulLatency (3)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        tk;
        logic        v;
        logic [31:0] imm;
        logic        mc;
        logic        kl;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [31:0] e_imm;
        logic        e_ce;
        logic        e_fl;
        logic [15:0] e_st;
    } vec_t;

    localparam int NVEC = 33;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic tk, logic v, logic [31:0] imm, logic mc,
                                logic kl, logic ordy, logic e_rdy, logic e_ov,
                                logic [31:0] e_imm, logic e_ce, logic e_fl,
                                logic [15:0] e_st);
        vec_t r;
        r.tk = tk; r.v = v; r.imm = imm; r.mc = mc; r.kl = kl; r.ordy = ordy;
        r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_imm = e_imm; r.e_ce = e_ce;
        r.e_fl = e_fl; r.e_st = e_st;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic tk, input logic v, input logic [31:0] imm,
                         input logic mc, input logic kl, input logic ordy);
        bus.tick          = tk;
        bus.in_valid      = v;
        bus.in_imm        = imm;
        bus.in_multicycle = mc;
        bus.in_kill       = kl;
        bus.out_ready     = ordy;
    endtask

    task automatic check_all(input string tag, input logic e_rdy, input logic e_ov,
                             input logic [31:0] e_imm, input logic e_ce,
                             input logic e_fl, input logic [15:0] e_st);
        check({tag, ".in_ready"},    32'(bus.in_ready),     32'(e_rdy));
        check({tag, ".out_valid"},   32'(bus.out_valid),    32'(e_ov));
        check({tag, ".Imm_D"},       bus.imm_d,             e_imm);
        check({tag, ".ClockEnable"}, 32'(bus.clock_enable), 32'(e_ce));
        check({tag, ".Flush"},       32'(bus.flush),        32'(e_fl));
        check({tag, ".StallCnt"},    32'(bus.stall_cnt),    32'(e_st));
    endtask

    localparam logic [31:0] IA = 32'h0000_1234;
    localparam logic [31:0] A1 = 32'hA000_0001;
    localparam logic [31:0] A2 = 32'hA000_0002;
    localparam logic [31:0] A3 = 32'hA000_0003;
    localparam logic [31:0] A4 = 32'hA000_0004;
    localparam logic [31:0] IB = 32'hB0B0_B0B0;
    localparam logic [31:0] IC = 32'hC0C0_C0C0;
    localparam logic [31:0] ID = 32'hD0D0_D0D0;
    localparam logic [31:0] IE = 32'hE0E0_E0E0;
    localparam logic [31:0] IF = 32'hF0F0_F0F0;
    localparam logic [31:0] IG = 32'h1111_2222;
    localparam logic [31:0] IH = 32'h3333_4444;

    initial begin
        n_checks = 0;
        n_errors = 0;

        //             tk v imm mc kl or | rdy ov immD ce fl st
        vecs[0]  = mk(1, 0, 0,  0, 0, 1,  1, 0, 0,  0, 0, 0);   // idle
        vecs[1]  = mk(1, 1, IA, 0, 0, 1,  1, 0, 0,  0, 0, 0);   // single op accept
        vecs[2]  = mk(1, 0, 0,  0, 0, 1,  1, 1, IA, 1, 0, 0);
        vecs[3]  = mk(1, 0, 0,  0, 0, 1,  1, 0, IA, 0, 0, 0);
        vecs[4]  = mk(1, 1, A1, 0, 0, 1,  1, 0, IA, 0, 0, 0);   // back-to-back
        vecs[5]  = mk(1, 1, A2, 0, 0, 1,  1, 1, A1, 1, 0, 0);
        vecs[6]  = mk(1, 1, A3, 0, 0, 1,  1, 1, A2, 1, 0, 0);
        vecs[7]  = mk(1, 1, A4, 0, 0, 1,  1, 1, A3, 1, 0, 0);
        vecs[8]  = mk(1, 0, 0,  0, 0, 1,  1, 1, A4, 1, 0, 0);
        vecs[9]  = mk(1, 0, 0,  0, 0, 1,  1, 0, A4, 0, 0, 0);
        vecs[10] = mk(1, 1, IB, 1, 0, 1,  1, 0, A4, 0, 0, 0);   // multicycle
        vecs[11] = mk(1, 0, 0,  0, 0, 1,  0, 0, IB, 0, 0, 0);
        vecs[12] = mk(1, 0, 0,  0, 0, 1,  0, 0, IB, 0, 0, 1);
        vecs[13] = mk(1, 0, 0,  0, 0, 1,  0, 0, IB, 0, 0, 2);
        vecs[14] = mk(1, 0, 0,  0, 0, 0,  0, 1, IB, 0, 0, 3);   // backpressure
        vecs[15] = mk(0, 0, 0,  0, 0, 0,  0, 1, IB, 0, 0, 4);
        vecs[16] = mk(1, 0, 0,  0, 0, 0,  0, 1, IB, 0, 0, 4);
        vecs[17] = mk(0, 0, 0,  0, 0, 0,  0, 1, IB, 0, 0, 5);
        vecs[18] = mk(1, 0, 0,  0, 0, 0,  0, 1, IB, 0, 0, 5);
        vecs[19] = mk(0, 0, 0,  0, 0, 1,  1, 1, IB, 0, 0, 6);
        vecs[20] = mk(1, 0, 0,  0, 0, 1,  1, 1, IB, 1, 0, 6);
        vecs[21] = mk(1, 0, 0,  0, 0, 1,  1, 0, IB, 0, 0, 6);
        vecs[22] = mk(1, 1, IC, 1, 0, 1,  1, 0, IB, 0, 0, 6);   // kill in WAIT cnt=1
        vecs[23] = mk(1, 0, 0,  0, 0, 1,  0, 0, IC, 0, 0, 6);
        vecs[24] = mk(1, 0, 0,  0, 1, 1,  0, 0, IC, 0, 0, 7);
        vecs[25] = mk(1, 0, 0,  0, 0, 1,  0, 0, 0,  0, 1, 8);
        vecs[26] = mk(1, 0, 0,  0, 0, 1,  1, 0, 0,  0, 0, 8);
        vecs[27] = mk(1, 1, ID, 0, 0, 1,  1, 0, 0,  0, 0, 8);   // kill beats accept in HOLD
        vecs[28] = mk(1, 1, IE, 0, 1, 1,  1, 1, ID, 0, 0, 8);
        vecs[29] = mk(1, 0, 0,  0, 0, 1,  0, 0, 0,  0, 1, 8);
        vecs[30] = mk(1, 0, 0,  0, 0, 1,  1, 0, 0,  0, 0, 8);
        vecs[31] = mk(0, 1, IF, 0, 0, 1,  1, 0, 0,  0, 0, 8);   // no accept without Tick
        vecs[32] = mk(1, 0, 0,  0, 0, 1,  1, 0, 0,  0, 0, 8);

        // Reset phase: create a real falling edge on rst_n
        drive(1, 1, IA, 0, 0, 1);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 check_all("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1 check("post_reset.in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].tk, vecs[i].v, vecs[i].imm, vecs[i].mc, vecs[i].kl, vecs[i].ordy);
            #1 check_all($sformatf("v%0d", i), vecs[i].e_rdy, vecs[i].e_ov,
                         vecs[i].e_imm, vecs[i].e_ce, vecs[i].e_fl, vecs[i].e_st);
        end

        // Asynchronous reset in the middle of HOLD
        @(negedge clk);
        drive(1, 1, IG, 0, 0, 1);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1);
        #1 check("midhold.pre_ov", 32'(bus.out_valid), 32'd1);
        check("midhold.pre_ce", 32'(bus.clock_enable), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_all("midhold_rst", 0, 0, 0, 0, 0, 0);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1 check_all("after_rel", 1, 0, 0, 0, 0, 0);

        // StallCnt saturation under long backpressure
        @(negedge clk);
        drive(1, 1, IH, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0);
        repeat (65540) @(negedge clk);
        #1 check_all("saturate", 0, 1, IH, 0, 0, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_is_stage_ctrl.md
EX_IS_STAGE_CTRL -- requirements
Module: ex_is_stage_ctrl

Interface
REQ-001 Parameter NrOfBits, default 32, SHALL set the width of the immediate path.
REQ-002 Parameter MulLatency, default 3, range 1..15, SHALL set the number of Tick-qualified stall cycles for a multicycle operation.
REQ-003 Clock  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Reset_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Tick  in  1  SHALL qualify every state, counter and data update; with Tick=0 all registers hold.
REQ-006 in_valid  in  1  SHALL mark a valid upstream immediate.
REQ-007 in_imm  in  NrOfBits  SHALL carry the upstream immediate.
REQ-008 in_multicycle  in  1  SHALL mark the accepted operation as multicycle.
REQ-009 in_kill  in  1  SHALL request a pipeline flush.
REQ-010 out_ready  in  1  SHALL mark downstream acceptance.
REQ-011 in_ready  out  1  SHALL tell upstream that a transfer is accepted this cycle.
REQ-012 out_valid  out  1  SHALL mark Imm_D as valid for the EX/IS register.
REQ-013 Imm_D  out  NrOfBits  SHALL drive the D input of the EX/IS immediate register.
REQ-014 ClockEnable  out  1  SHALL drive the EX/IS register ClockEnable.
REQ-015 Flush  out  1  SHALL drive the EX/IS register active-high Reset.
REQ-016 StallCnt  out  16  SHALL report the number of stalled Tick cycles.

Function
REQ-017 States SHALL be IDLE, WAIT, HOLD and FLUSH, held in a registered state machine.
REQ-018 An accept SHALL occur when in_valid & in_ready & Tick are all 1.
REQ-019 in_ready SHALL be 1 in IDLE, SHALL equal out_ready in HOLD, and SHALL be 0 in WAIT and FLUSH.
REQ-020 On an accept, in_imm SHALL be latched; next state SHALL be WAIT with cnt=MulLatency-1 if in_multicycle=1, else HOLD.
REQ-021 In WAIT with Tick=1: if cnt=0, next state SHALL be HOLD; otherwise cnt SHALL decrement, so WAIT lasts exactly MulLatency Tick cycles.
REQ-022 out_valid SHALL be 1 only in HOLD; Imm_D SHALL always equal the latched immediate.
REQ-023 ClockEnable SHALL be combinational and equal out_valid & out_ready & Tick.
REQ-024 In HOLD with out_ready & Tick: if an accept occurs, the new immediate SHALL be taken per REQ-020 (back-to-back, no bubble); otherwise next state SHALL be IDLE.
REQ-025 in_kill & Tick SHALL take priority over every other event in any state: next state FLUSH, no accept, cnt cleared, and ClockEnable forced to 0 that cycle.
REQ-026 In FLUSH, Flush SHALL be 1 for exactly one cycle; next state SHALL be IDLE, or FLUSH again if in_kill & Tick is 1.
REQ-027 Flush SHALL be 0 in every state other than FLUSH.
REQ-028 StallCnt SHALL increment on each Tick cycle spent in WAIT, or in HOLD with out_ready=0, and SHALL saturate at 16'hFFFF.
REQ-029 The latched immediate SHALL be cleared to 0 on entry to FLUSH.

Reset
REQ-030 Reset_n=0 SHALL immediately force state IDLE, immediate 0, cnt 0, StallCnt 0, out_valid 0, ClockEnable 0 and Flush 0.
REQ-031 in_ready SHALL be 0 while Reset_n=0 and SHALL become 1 on the first cycle after release.
REQ-032 Reset asserted in the middle of a WAIT or HOLD SHALL discard the operation; no ClockEnable pulse SHALL follow.

Verification
REQ-033 Single op: in_imm=32'h0000_1234, in_multicycle=0, Tick=1, out_ready=1 -> one cycle later out_valid=1, Imm_D=32'h0000_1234, ClockEnable=1 for 1 cycle, then IDLE.
REQ-034 Multicycle: MulLatency=3, in_multicycle=1 -> out_valid rises exactly 3 Tick cycles after the accept; StallCnt=3.
REQ-035 Backpressure and Tick gating: out_ready=0 for 5 cycles in HOLD with Tick alternating 1/0 -> Imm_D stable, StallCnt=3, in_ready=0 throughout.
REQ-036 Back-to-back: 4 non-multicycle ops with out_ready=1 -> 4 consecutive ClockEnable pulses with values in order, no bubbles.
REQ-037 Kill during WAIT with cnt=1 -> Flush=1 for 1 cycle, Imm_D=0, then IDLE, out_valid never 1.
REQ-038 Reset_n pulsed low mid-HOLD, asynchronous to Clock -> all outputs 0 immediately, in_ready=1 on the first cycle after release.
